dmt_timing_generate_param: RTL

//  Parametrised DMT/CEA video timing generator for the HDMI output path; drives hsync/vsync/de to the TMDS encoder.

---
 rtl/dmt_timing_generate_param_if.sv | 24 ++
 rtl/dmt_timing_generate_param.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmt_timing_generate_param_if.sv
// Video timing bundle between the timing generator and the TMDS/frame-buffer side.
// The generator drives the timing outputs; the consumer side drives the run enable.
interface dmt_timing_generate_param_if #(
   parameter int CNT_W = 12
);
   logic             en;
   logic             hsync;
   logic             vsycn;
   logic             de;
   logic             req;
   logic [CNT_W-1:0] req_x;
   logic [CNT_W-1:0] req_y;
   logic             frame_start;

   modport master (
      input  en,
      output hsync, vsycn, de, req, req_x, req_y, frame_start
   );

   modport slave (
      output en,
      input  hsync, vsycn, de, req, req_x, req_y, frame_start
   );
endinterface

// File: rtl/dmt_timing_generate_param.sv
// Parameter-driven DMT/CEA timing generator: hsync/vsycn/de plus a leading pixel-fetch
// request with coordinates, a frame-start pulse and frame-boundary run/stop control.
module dmt_timing_generate_param #(
   parameter int CNT_W    = 12,
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int REQ_LEAD = 2
) (
   input  logic                               pixe_clk,
   input  logic                               rest,
   dmt_timing_generate_param_if.master        tim
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

   // One extra bit so hcnt+REQ_LEAD cannot wrap before the window compare.
   localparam logic [CNT_W:0]   REQ_BEG    = (CNT_W+1)'(H_SYNC + H_BP);
   localparam logic [CNT_W:0]   REQ_END    = (CNT_W+1)'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [CNT_W:0]   LEAD       = (CNT_W+1)'(REQ_LEAD);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] hcnt_reg, vcnt_reg;
   logic             frame_end;
   logic             running;

   logic             hsync_reg, hsync_next;
   logic             vsycn_reg, vsycn_next;
   logic             de_reg, de_next;
   logic             req_reg, req_next;
   logic [CNT_W-1:0] req_x_reg, req_x_next;
   logic [CNT_W-1:0] req_y_reg, req_y_next;
   logic             frame_start_reg, frame_start_next;

   logic [CNT_W:0]   h_lead;
   logic             v_act;

   assign running   = (state_reg == ST_RUN);
   assign frame_end = (hcnt_reg == H_LAST) && (vcnt_reg == V_LAST);

   always_ff @(posedge pixe_clk) begin
      if (rest) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // en only matters while idle or on the last cycle of a frame.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (tim.en) state_next = ST_RUN;
         ST_RUN:  if (frame_end && !tim.en) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge pixe_clk) begin
      if (rest) begin
         hcnt_reg <= '0;
         vcnt_reg <= '0;
      end else if (running) begin
         if (hcnt_reg == H_LAST) begin
            hcnt_reg <= '0;
            vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
         end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
         end
      end
   end

   assign h_lead = {1'b0, hcnt_reg} + LEAD;
   assign v_act  = (vcnt_reg >= V_ACT_BEG) && (vcnt_reg < V_ACT_END);

   always_comb begin
      hsync_next       = ~HS_POL;
      vsycn_next       = ~VS_POL;
      de_next          = 1'b0;
      req_next         = 1'b0;
      req_x_next       = '0;
      req_y_next       = '0;
      frame_start_next = 1'b0;
      if (running) begin
         if (hcnt_reg < H_SYNC_END) hsync_next = HS_POL;
         if (vcnt_reg < V_SYNC_END) vsycn_next = VS_POL;
         de_next          = v_act && (hcnt_reg >= H_ACT_BEG) && (hcnt_reg < H_ACT_END);
         req_next         = v_act && (h_lead >= REQ_BEG) && (h_lead < REQ_END);
         frame_start_next = (hcnt_reg == '0) && (vcnt_reg == '0);
         if (req_next) begin
            req_x_next = CNT_W'(h_lead - REQ_BEG);
            req_y_next = vcnt_reg - V_ACT_BEG;
         end
      end
   end

   always_ff @(posedge pixe_clk) begin
      if (rest) begin
         hsync_reg       <= ~HS_POL;
         vsycn_reg       <= ~VS_POL;
         de_reg          <= 1'b0;
         req_reg         <= 1'b0;
         req_x_reg       <= '0;
         req_y_reg       <= '0;
         frame_start_reg <= 1'b0;
      end else begin
         hsync_reg       <= hsync_next;
         vsycn_reg       <= vsycn_next;
         de_reg          <= de_next;
         req_reg         <= req_next;
         req_x_reg       <= req_x_next;
         req_y_reg       <= req_y_next;
         frame_start_reg <= frame_start_next;
      end
   end

   assign tim.hsync       = hsync_reg;
   assign tim.vsycn       = vsycn_reg;
   assign tim.de          = de_reg;
   assign tim.req         = req_reg;
   assign tim.req_x       = req_x_reg;
   assign tim.req_y       = req_y_reg;
   assign tim.frame_start = frame_start_reg;

endmodule
